// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - multi-cycle signed Booth multiply / restoring divide engine
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    // acc: Booth accumulator (mul) or partial remainder (div), one guard bit wide
    logic [WIDTH:0]   acc_q, acc_d;
    // q: multiplier being shifted out (mul) or dividend/quotient shift register (div)
    logic [WIDTH-1:0] q_q, q_d;
    logic             qm1_q, qm1_d;
    // m: multiplicand (mul) or divisor magnitude (div)
    logic [WIDTH-1:0] m_q, m_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   trial;
    logic             last_iter;

    assign m_ext     = {m_q[WIDTH-1], m_q};
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // Next-state and datapath: one iteration per cycle, results only written on completion
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;
        booth_sum = acc_q;
        r_sh      = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        trial     = r_sh - {1'b0, m_q};

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    dbz_d  = 1'b0;
                    busy_d = 1'b1;
                    cnt_d  = '0;
                    acc_d  = '0;
                    qm1_d  = 1'b0;
                    if (!op) begin
                        state_d = S_MUL;
                        m_d     = a;
                        q_d     = b;
                    end else if (b != '0) begin
                        state_d = S_DIV;
                        m_d     = b[WIDTH-1] ? -b : b;
                        q_d     = a[WIDTH-1] ? -a : a;
                        sa_d    = a[WIDTH-1];
                        sb_d    = b[WIDTH-1];
                    end else begin
                        // Divide by zero finishes immediately with a fixed result
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        dbz_d   = 1'b1;
                        hi_d    = a;
                        lo_d    = {WIDTH{1'b1}};
                    end
                end
            end
            S_MUL: begin
                case ({q_q[0], qm1_q})
                    2'b01:   booth_sum = acc_q + m_ext;
                    2'b10:   booth_sum = acc_q - m_ext;
                    default: booth_sum = acc_q;
                endcase
                acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    hi_d    = booth_sum[WIDTH:1];
                    lo_d    = {booth_sum[0], q_q[WIDTH-1:1]};
                end
            end
            S_DIV: begin
                // Remainder stays below 2^WIDTH, so the guard bit is the sign of the trial
                acc_d = trial[WIDTH] ? r_sh : trial;
                q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // Truncating division: quotient sign from operand signs, remainder follows dividend
                lo_d    = (sa_q ^ sb_q) ? -q_q : q_q;
                hi_d    = sa_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            m_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result_hi   = hi_q;
    assign result_lo   = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - vector table, corner sequences and randomized model check for mul_div_unit
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result_hi;
    logic [31:0] result_lo;
    logic        div_by_zero;

    int n_cmp  = 0;
    int n_fail = 0;

    logic        p_op;
    logic [31:0] p_a;
    logic [31:0] p_b;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result_hi  (result_hi),
        .result_lo  (result_lo),
        .div_by_zero(div_by_zero)
    );

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic with truncating division semantics
    function automatic void model(input logic mop, input logic [31:0] ma, input logic [31:0] mb,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic dbz, output int lat);
        longint p;
        int     sa;
        int     sb;
        dbz = 1'b0;
        if (!mop) begin
            p   = longint'($signed(ma)) * longint'($signed(mb));
            hi  = p[63:32];
            lo  = p[31:0];
            lat = 33;
        end else if (mb == 32'd0) begin
            hi  = ma;
            lo  = 32'hFFFFFFFF;
            dbz = 1'b1;
            lat = 1;
        end else if (ma == 32'h80000000 && mb == 32'hFFFFFFFF) begin
            hi  = 32'd0;
            lo  = 32'h80000000;
            lat = 34;
        end else begin
            sa  = $signed(ma);
            sb  = $signed(mb);
            lo  = sa / sb;
            hi  = sa % sb;
            lat = 34;
        end
    endfunction

    // Runs one operation. pre: start already driven by previous done cycle.
    // pulse_at: cycle index at which a stray start is pulsed while busy (-1 none).
    // bb: leave start asserted with p_* operands in the done cycle.
    task automatic run_check(input string name, input logic iop, input logic [31:0] ia,
                             input logic [31:0] ib, input logic [31:0] ehi, input logic [31:0] elo,
                             input logic edbz, input int elat, input int pulse_at,
                             input logic bb, input logic pre);
        int   n;
        int   lat;
        logic busy_ok;
        logic seen;
        busy_ok = 1'b1;
        seen    = 1'b0;
        lat     = -1;
        if (pre) begin
            @(posedge clk);
            @(negedge clk);
            check({name, "_not_accepted_in_done"}, {63'd0, busy}, 64'd0);
        end else begin
            @(negedge clk);
            start = 1'b1;
            op    = iop;
            a     = ia;
            b     = ib;
        end
        @(posedge clk);
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            start = 1'b0;
            op    = $urandom_range(0, 1);
            a     = $urandom;
            b     = $urandom;
            if (n == pulse_at) begin
                start = 1'b1;
                op    = p_op;
                a     = p_a;
                b     = p_b;
            end
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                seen = 1'b1;
                lat  = n + 1;
                if (bb) begin
                    start = 1'b1;
                    op    = p_op;
                    a     = p_a;
                    b     = p_b;
                end
                break;
            end
            @(posedge clk);
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: done not seen, required within 200 cycles", name);
            return;
        end
        check({name, "_lat"}, 64'(lat), 64'(elat));
        check({name, "_busy"}, {63'd0, busy_ok}, 64'd1);
        check({name, "_hi"}, {32'd0, result_hi}, {32'd0, ehi});
        check({name, "_lo"}, {32'd0, result_lo}, {32'd0, elo});
        check({name, "_dbz"}, {63'd0, div_by_zero}, {63'd0, edbz});
        if (!bb) begin
            @(negedge clk);
            check({name, "_done_fall"}, {62'd0, done, busy}, 64'd0);
            check({name, "_hold"}, {result_hi, result_lo}, {ehi, elo});
        end
    endtask

    vec_t        vecs[10];
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edbz;
    int          elat;

    initial begin
        vecs[0] = '{1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
        vecs[1] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
        vecs[2] = '{1'b1, 32'hFFFFFFEF, 32'd5,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 34};
        vecs[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
        vecs[4] = '{1'b1, 32'd42,       32'd0,        32'd42,       32'hFFFFFFFF, 1'b1, 1};
        vecs[5] = '{1'b0, 32'd0,        32'd0,        32'd0,        32'd0,        1'b0, 33};
        vecs[6] = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 33};
        vecs[7] = '{1'b1, 32'd17,       32'hFFFFFFFB, 32'd2,        32'hFFFFFFFD, 1'b0, 34};
        vecs[8] = '{1'b1, 32'hFFFFFFEF, 32'hFFFFFFFB, 32'hFFFFFFFE, 32'd3,        1'b0, 34};
        vecs[9] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 33};

        rst   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        p_op  = 1'b0;
        p_a   = '0;
        p_b   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {61'd0, busy, done, div_by_zero}, 64'd0);
        check("reset_res", {result_hi, result_lo}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                      vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].lat, -1, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd7;
        b     = 32'hFFFFFFFD;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midreset_ctrl", {61'd0, busy, done, div_by_zero}, 64'd0);
        check("midreset_res", {result_hi, result_lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_check("after_reset", 1'b0, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 33, -1, 1'b0, 1'b0);

        // Stray start while busy is ignored
        p_op = 1'b1;
        p_a  = 32'd100;
        p_b  = 32'd7;
        run_check("busy_ignore", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 33, 5, 1'b0, 1'b0);

        // Start held in the done cycle is taken on the following idle edge
        p_op = 1'b1;
        p_a  = 32'd100;
        p_b  = 32'hFFFFFFF9;
        run_check("b2b_first", 1'b0, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0, 33, -1, 1'b1, 1'b0);
        run_check("b2b_second", 1'b1, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 1'b0, 34,
                  -1, 1'b0, 1'b1);

        // Randomized operands against the model
        for (int i = 0; i < 40; i++) begin
            logic        rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = $urandom_range(0, 1);
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: ra = 32'h80000000;
                3: rb = $urandom_range(1, 20);
                default: ;
            endcase
            model(rop, ra, rb, ehi, elo, edbz, elat);
            run_check($sformatf("rand%0d", i), rop, ra, rb, ehi, elo, edbz, elat, -1, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
